// File: rtl/if_fetch_master.sv
// Instruction-fetch front end: owns the PC, runs Wishbone classic reads to
// instruction memory and hands the fetched word plus its PC to IF/ID.
module if_fetch_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                pc_stall_and_flush,
    input  logic [ADDR_WIDTH-1:0]     branch_target,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic [ADDR_WIDTH-1:0]     wb_adr_o,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_ack_i,
    output logic [DATA_WIDTH-1:0]     inst_o,
    output logic [ADDR_WIDTH-1:0]     pc_o,
    output logic                      inst_valid,
    output logic                      im_busy
);

    localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(32'd4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_M  = ~ADDR_WIDTH'(32'd3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
    logic                    valid_q, valid_d;

    logic                    stall_s;
    logic                    flush_s;
    logic [ADDR_WIDTH-1:0]   tgt_s;

    assign stall_s = pc_stall_and_flush[0];
    assign flush_s = pc_stall_and_flush[1];
    assign tgt_s   = branch_target & ALIGN_M;

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        adr_d    = adr_q;
        cyc_d    = cyc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                cyc_d   = 1'b1;
                if (flush_s) begin
                    pc_d  = tgt_s;
                    adr_d = tgt_s;
                end else begin
                    adr_d = pc_q;
                end
            end
            FETCH: begin
                if (wb_ack_i && !flush_s) begin
                    inst_d   = wb_dat_i;
                    pc_out_d = pc_q;
                    cyc_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (wb_ack_i) begin
                    pc_d    = tgt_s;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (flush_s) begin
                    // Bus cycle must run to completion; its data is dropped later.
                    pc_d    = tgt_s;
                    state_d = DISCARD;
                end else begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (flush_s) begin
                    pc_d = tgt_s;
                end else begin
                    pc_d = pc_q;
                end
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DISCARD;
                end
            end
            DONE: begin
                if (flush_s) begin
                    pc_d    = tgt_s;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (stall_s) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + PC_STEP;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any bus cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_ADDR;
            adr_q    <= PC_ADDR;
            cyc_q    <= 1'b0;
            inst_q   <= NOP_INST;
            pc_out_q <= PC_ADDR;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            adr_q    <= adr_d;
            cyc_q    <= cyc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = {(DATA_WIDTH/8){1'b1}};
    assign wb_adr_o   = adr_q;
    assign inst_o     = inst_q;
    assign pc_o       = pc_out_q;
    assign inst_valid = valid_q;
    assign im_busy    = (state_q != DONE);

endmodule

// File: tb/tb_if_fetch_master.sv
// Directed bench for if_fetch_master: a bus-event model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_if_fetch_master;

    localparam logic [31:0] PC0 = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sf;
    logic [31:0] tgt;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] inst, pco;
    logic        valid, busy;

    int total = 0;
    int bad   = 0;

    if_fetch_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_ADDR(PC0)) dut (
        .clk(clk), .reset(reset), .pc_stall_and_flush(sf), .branch_target(tgt),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel), .wb_adr_o(adr),
        .wb_dat_i(dat), .wb_ack_i(ack), .inst_o(inst), .pc_o(pco),
        .inst_valid(valid), .im_busy(busy)
    );

    always #5 clk = ~clk;

    // Event-level model: a bus cycle is open or not, may be poisoned by a
    // flush, and an instruction is either being presented or not.
    logic        m_live = 1'b0;
    logic        m_cyc, m_poison, m_valid;
    logic [31:0] m_pc, m_adr, m_inst, m_pco;

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1; m_cyc = 1'b0; m_poison = 1'b0; m_valid = 1'b0;
            m_pc = PC0; m_adr = PC0; m_inst = NOP; m_pco = PC0;
        end else if (m_live) begin
            if (m_valid) begin
                if (sf[1]) begin
                    m_pc = tgt & 32'hFFFF_FFFC; m_valid = 1'b0;
                end else if (!sf[0]) begin
                    m_pc = m_pc + 32'd4; m_valid = 1'b0;
                end
            end else if (m_cyc) begin
                if (sf[1]) m_pc = tgt & 32'hFFFF_FFFC;
                if (ack) begin
                    m_cyc = 1'b0;
                    if (!m_poison && !sf[1]) begin
                        m_valid = 1'b1; m_inst = dat; m_pco = m_adr;
                    end
                    m_poison = 1'b0;
                end else if (sf[1]) begin
                    m_poison = 1'b1;
                end
            end else begin
                if (sf[1]) m_pc = tgt & 32'hFFFF_FFFC;
                m_cyc = 1'b1;
                m_adr = m_pc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc",   {31'd0, cyc},   {31'd0, m_cyc});
            chk("stb",   {31'd0, stb},   {31'd0, m_cyc});
            chk("we",    {31'd0, we},    32'd0);
            chk("sel",   {28'd0, sel},   32'h0000_000F);
            if (m_cyc) chk("adr", adr, m_adr);
            chk("inst",  inst,           m_inst);
            chk("pc_o",  pco,            m_pco);
            chk("valid", {31'd0, valid}, {31'd0, m_valid});
            chk("busy",  {31'd0, busy},  {31'd0, !m_valid});
        end
    end

    task automatic step(input logic r, input logic [1:0] f, input logic [31:0] t,
                        input logic a, input logic [31:0] d);
        reset = r; sf = f; tgt = t; ack = a; dat = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; sf = 2'b00; tgt = 32'd0; ack = 1'b0; dat = 32'd0;
        @(negedge clk);
        step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
        chk("rst_cyc",   {31'd0, cyc},   32'd0);
        chk("rst_adr",   adr,            32'h8000_0000);
        chk("rst_inst",  inst,           32'h0000_0013);
        chk("rst_pc",    pco,            32'h8000_0000);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd1);

        // First fetch with a zero-wait ack.
        idle_step();
        chk("t1_cyc", {31'd0, cyc}, 32'd1);
        chk("t1_adr", adr, 32'h8000_0000);
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'h0050_0093);
        chk("t1_inst",  inst, 32'h0050_0093);
        chk("t1_pc",    pco,  32'h8000_0000);
        chk("t1_valid", {31'd0, valid}, 32'd1);
        chk("t1_busy",  {31'd0, busy},  32'd0);

        // Stall held in DONE.
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 32'd0, 1'b0, 32'd0);
        chk("t2_inst", inst, 32'h0050_0093);
        chk("t2_pc",   pco,  32'h8000_0000);
        chk("t2_cyc",  {31'd0, cyc},  32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        idle_step();
        idle_step();
        chk("t2_adr", adr, 32'h8000_0004);

        // Flush during FETCH with delayed ack; the returned data is never shown.
        step(1'b0, 2'b10, 32'h8000_1002, 1'b0, 32'd0);
        chk("t3_adr_a", adr, 32'h8000_0004);
        idle_step();
        idle_step();
        chk("t3_adr_b", adr, 32'h8000_0004);
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'hDEAD_BEEF);
        chk("t3_cyc",   {31'd0, cyc},   32'd0);
        chk("t3_valid", {31'd0, valid}, 32'd0);
        idle_step();
        chk("t3_adr_c", adr, 32'h8000_1000);
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'h0000_0001);
        chk("t3_pc", pco, 32'h8000_1000);

        // Flush and stall together in DONE: flush wins.
        step(1'b0, 2'b11, 32'h8000_0100, 1'b0, 32'd0);
        chk("t4_valid", {31'd0, valid}, 32'd0);
        idle_step();
        chk("t4_adr", adr, 32'h8000_0100);

        // Flush coincident with ack.
        step(1'b0, 2'b10, 32'h8000_2000, 1'b1, 32'h1111_1111);
        chk("t5_valid", {31'd0, valid}, 32'd0);
        chk("t5_cyc",   {31'd0, cyc},   32'd0);
        idle_step();
        chk("t5_adr", adr, 32'h8000_2000);

        // Two flushes during one bus cycle: newest target is fetched next.
        step(1'b0, 2'b10, 32'h8000_3000, 1'b0, 32'd0);
        step(1'b0, 2'b10, 32'h8000_4000, 1'b1, 32'h2222_2222);
        idle_step();
        chk("t6_adr", adr, 32'h8000_4000);

        // Redirect to the top of memory; increment wraps to zero.
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'h3333_3333);
        step(1'b0, 2'b10, 32'hFFFF_FFFF, 1'b0, 32'd0);
        idle_step();
        chk("t7_adr", adr, 32'hFFFF_FFFC);
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'h4444_4444);
        chk("t7_pc", pco, 32'hFFFF_FFFC);
        idle_step();
        idle_step();
        chk("t7_wrap", adr, 32'h0000_0000);

        // Reset mid-FETCH, then a stale ack.
        step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
        chk("t8_cyc", {31'd0, cyc}, 32'd0);
        step(1'b1, 2'b00, 32'd0, 1'b1, 32'h5555_5555);
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'h6666_6666);
        chk("t8_adr",   adr, 32'h8000_0000);
        chk("t8_valid", {31'd0, valid}, 32'd0);
        step(1'b0, 2'b00, 32'd0, 1'b1, 32'h00A0_0113);
        chk("t8_inst", inst, 32'h00A0_0113);
        chk("t8_pc",   pco,  32'h8000_0000);
        idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_master.md
Name: if_fetch_master

Overview:
- Instruction-fetch front end: owns the architectural PC and runs Wishbone classic read cycles to instruction memory.
- Presents the fetched instruction and its PC to the IF/ID register.
- Drives im_busy back to the pipeline stall/flush controller.
- Honours the controller's PC stall/flush pair, using bit 0 = stall and bit 1 = flush.

Parameters:
- PC_ADDR, 32'h8000_0000, PC value loaded on reset.
- ADDR_WIDTH, 32, width of the PC and Wishbone address.
- DATA_WIDTH, 32, width of the instruction and Wishbone data.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- reset  input  1  Synchronous, active-high reset.
- pc_stall_and_flush  input  2  From the stall/flush controller; [0] = stall, [1] = flush/redirect.
- branch_target  input  ADDR_WIDTH  Redirect address; sampled only when pc_stall_and_flush[1] = 1.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe; always equal to wb_cyc_o.
- wb_we_o  output  1  Constant 0.
- wb_sel_o  output  DATA_WIDTH/8  All ones.
- wb_adr_o  output  ADDR_WIDTH  Fetch address.
- wb_dat_i  input  DATA_WIDTH  Read data.
- wb_ack_i  input  1  Wishbone acknowledge.
- inst_o  output  DATA_WIDTH  Fetched instruction.
- pc_o  output  ADDR_WIDTH  PC of inst_o.
- inst_valid  output  1  inst_o/pc_o hold a live instruction.
- im_busy  output  1  Fetch not complete; to the stall/flush controller.

Behaviour:
- Reset (synchronous, dominates all other inputs, also mid-transaction):
  - state = IDLE, pc_reg = PC_ADDR.
  - wb_cyc_o = wb_stb_o = 0, wb_adr_o = PC_ADDR.
  - inst_o = 32'h0000_0013 (NOP), pc_o = PC_ADDR, inst_valid = 0.
  - A bus cycle in progress at reset is abandoned; a wb_ack_i arriving after reset with cyc = 0 is ignored.
- Outputs:
  - wb_cyc_o/wb_stb_o are registered, asserted exactly in FETCH and DISCARD.
  - im_busy is combinational: im_busy = (state != DONE).
  - inst_valid is registered: 1 only in DONE.
- IDLE:
  - cyc = 0.
  - Next edge goes to FETCH with wb_adr_o <= pc_reg.
  - If flush is asserted: pc_reg <= target first, and the fetch uses the new target.
- FETCH (cyc = stb = 1, adr held stable):
  - ack = 1, flush = 0: inst_o <= wb_dat_i, pc_o <= pc_reg, cyc <= 0, go to DONE.
  - ack = 1, flush = 1: drop data, pc_reg <= target, cyc <= 0, go to IDLE (one-cycle bus gap).
  - ack = 0, flush = 1: pc_reg <= target, go to DISCARD; cyc/stb/adr are held (no abandoned cycles).
  - ack = 0, flush = 0: stay.
  - stall is ignored in FETCH.
- DISCARD (cyc = stb = 1, old address):
  - A further flush overwrites pc_reg with the newest target.
  - On ack: data dropped, cyc <= 0, go to IDLE.
- DONE (cyc = 0):
  - flush = 1 (priority over stall): pc_reg <= target, inst_valid <= 0, go to IDLE.
  - flush = 0, stall = 1: hold everything.
  - flush = 0, stall = 0: pc_reg <= pc_reg + 4, inst_valid <= 0, go to IDLE.
- Arithmetic:
  - PC increment is modulo 2^ADDR_WIDTH (0xFFFF_FFFC + 4 = 0x0000_0000).
  - Redirect target bits [1:0] are forced to 0.
- Latency:
  - Minimum 3 cycles per instruction: IDLE → FETCH → DONE, with a zero-wait-state ack.
  - inst_valid rises on the edge that samples ack.

Test Plan:
- Reset release, ack returned in the first FETCH cycle with data 0x00500093 → wb_adr_o = 0x80000000 while cyc = 1; next cycle inst_o = 0x00500093, pc_o = 0x80000000, inst_valid = 1, im_busy = 0; then the next fetch is at 0x80000004.
- DONE with stall held 5 cycles → inst_o/pc_o are unchanged, cyc stays 0, im_busy = 0; on stall release the next adr is 0x80000004.
- Flush with target 0x80001002 during FETCH, ack delayed 3 cycles:
  - adr stays 0x80000004 until ack; returned data is never shown (inst_valid stays 0).
  - After one cyc-low cycle, fetch at 0x80001000.
- Flush and stall together in DONE, target 0x80000100 → stall is ignored; next fetch adr = 0x80000100.
- Flush coincident with ack in FETCH → ack data dropped, inst_valid stays 0, IDLE for one cycle, then fetch at the target.
- Reset asserted mid-FETCH, then a stale ack → cyc drops the cycle after reset; the stale ack has no effect; after release the first fetch is at 0x80000000 and pc_o = 0x80000000.
